receiver: RTL and testbench
===========================

RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame; only 8 is required to be supported.
REQ-002 tx_clk  input  1  bit-rate clock, same clock as the transmitter; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx_enable  input  1  permits detection of a new start bit; sampled only in IDLE.
REQ-005 rx_data_in  input  1  serial line, idle high; sampled directly each edge, with no synchronizer, because it is same-clock.
REQ-006 rx_data_out  output  8  last received data byte; registered; updated only at frame completion.
REQ-007 rx_valid  output  1  one-cycle pulse marking frame completion.
REQ-008 parity_error  output  1  received parity bit differs from even parity of data; qualifies rx_valid.
REQ-009 framing_error  output  1  stop bit sampled 0; qualifies rx_valid.
REQ-010 busy  output  1  frame reception in progress.

Function
REQ-011 Frame format: start bit (0), 8 data bits LSB first, parity bit (even: XOR of the 8 data bits), stop bit (1). One bit per tx_clk cycle.
REQ-012 States: IDLE, DATA, PARITY, STOP, WAIT_IDLE.
REQ-013 IDLE: on an edge with rx_enable=1 and rx_data_in=0 (call this edge S), go to DATA and clear the bit counter. Otherwise stay in IDLE.
REQ-014 DATA: edges S+1..S+8 shift rx_data_in into an internal shift register, LSB first (bit i sampled at edge S+1+i). After the 8th bit, go to PARITY.
REQ-015 PARITY: edge S+9 captures the parity bit, then go to STOP.
REQ-016 STOP, edge S+10, all in one edge:
- rx_data_out <= shift register;
- rx_valid <= 1;
- parity_error <= (XOR of data) XOR parity bit;
- framing_error <= ~rx_data_in.
REQ-017 STOP transition: next state is IDLE if the stop bit is 1, and WAIT_IDLE if it is 0.
REQ-018 WAIT_IDLE: stay there while rx_data_in=0; go to IDLE on the first edge sampling 1. No start detection occurs in WAIT_IDLE.
REQ-019 rx_valid is high for exactly one cycle, the cycle following edge S+10, and is deasserted on the next edge.
REQ-020 parity_error and framing_error are held until the next frame completion, which overwrites them.
REQ-021 rx_data_out holds its value between completions. It is written on every completed frame, including errored frames.
REQ-022 busy is high whenever the state is DATA, PARITY or STOP, and low in IDLE and WAIT_IDLE. It is registered, so it is high from just after edge S to just after edge S+10.
REQ-023 Back-to-back frames: a start bit sampled at edge S+11 begins a new frame, with no idle cycle required. rx_valid pulses are then 11 cycles apart.
REQ-024 rx_enable is ignored outside IDLE; deassertion mid-frame does not abort the frame.
REQ-025 Latency: 11 tx_clk edges from start-bit sample to the rx_valid rising.

Reset
REQ-026 While rst_n=0, outputs are:
- state = IDLE;
- rx_data_out = 8'h00;
- rx_valid = 0;
- parity_error = 0;
- framing_error = 0;
- busy = 0;
- shift register and bit counter = 0.
REQ-027 Reset asserted mid-frame aborts the frame immediately, with no rx_valid pulse. After release, reception restarts in IDLE.

Verification
REQ-028 Send 0xA5 with parity 0 and stop 1 -> rx_valid pulses once 11 cycles after the start sample; rx_data_out=0xA5; parity_error=0; framing_error=0.
REQ-029 Send 0x01 with parity bit forced to 0 -> rx_data_out=0x01, parity_error=1, framing_error=0; then send 0x03 with parity 0 -> parity_error clears to 0.
REQ-030 Send 0x5A with stop bit 0, then hold the line low 3 cycles, then high -> framing_error=1; no new frame is started during the low cycles; busy=0; a following 0x7E frame is received correctly.
REQ-031 Send 0x3C and 0xC3 back-to-back with zero idle cycles -> two rx_valid pulses 11 cycles apart carrying 0x3C then 0xC3, both error-free.
REQ-032 Assert rst_n=0 after 4 data bits of 0xFF -> no rx_valid; all outputs reset; a subsequent 0x81 is received correctly.
REQ-033 Hold rx_enable=0 while the line carries a start bit -> remains in IDLE, busy=0, no rx_valid. Loopback with the transmitter on data 0x00..0xFF -> every byte matches with no errors.

Source files
------------

// File: rtl/receiver_if.sv
// ---------------------------------------------------------------------------
// receiver_if
// Bundles the serial receiver's control, line and result signals.
//   rx_enable      : permits start-bit detection while the receiver is idle
//   rx_data_in     : serial line, idle high, same clock as the transmitter
//   rx_data_out    : last received data byte
//   rx_valid       : one-cycle frame completion pulse
//   parity_error   : parity bit mismatch, qualifies rx_valid
//   framing_error  : stop bit sampled low, qualifies rx_valid
//   busy           : frame reception in progress
// Modports: master drives the line side (testbench / upstream logic),
//           slave is the receiver itself.
// ---------------------------------------------------------------------------
interface receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_enable;
    logic                  rx_data_in;
    logic [DATA_WIDTH-1:0] rx_data_out;
    logic                  rx_valid;
    logic                  parity_error;
    logic                  framing_error;
    logic                  busy;

    modport master (
        output rx_enable,
        output rx_data_in,
        input  rx_data_out,
        input  rx_valid,
        input  parity_error,
        input  framing_error,
        input  busy
    );

    modport slave (
        input  rx_enable,
        input  rx_data_in,
        output rx_data_out,
        output rx_valid,
        output parity_error,
        output framing_error,
        output busy
    );
endinterface

// File: rtl/receiver.sv
// ---------------------------------------------------------------------------
// receiver
// Same-clock serial frame receiver: start(0), DATA_WIDTH data bits LSB
// first, even parity bit, stop(1). One bit per tx_clk cycle, line sampled
// directly (no synchronizer) since it shares the transmitter's clock.
//
// Ports:
//   tx_clk : bit-rate clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : receiver_if.slave (rx_enable, rx_data_in in;
//            rx_data_out, rx_valid, parity_error, framing_error, busy out)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a start bit (needs rx_enable=1, line=0)
// DATA      | shifting in data bits, LSB first
// PARITY    | capturing the parity bit
// STOP      | sampling stop bit, publishing byte and error flags
// WAIT_IDLE | stop bit was 0; wait for line to return high
// ---------------------------------------------------------------------------
module receiver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic       tx_clk,
    input  logic       rst_n,
    receiver_if.slave  bus
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        PARITY    = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  parity_bit;

    logic                  start_det;
    logic                  shift_en;
    logic                  parity_cap;
    logic                  frame_done;
    logic                  busy_nxt;

    // State register
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.rx_enable && !bus.rx_data_in) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_cnt == CNT_LAST) begin
                    state_nxt = PARITY;
                end
            end
            PARITY: begin
                state_nxt = STOP;
            end
            STOP: begin
                // A low stop bit means the line may still be held low; refuse
                // to treat it as a new start bit until it has gone high again.
                state_nxt = bus.rx_data_in ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (bus.rx_data_in) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        start_det  = (state == IDLE) && bus.rx_enable && !bus.rx_data_in;
        shift_en   = (state == DATA);
        parity_cap = (state == PARITY);
        frame_done = (state == STOP);
        // busy is registered from the next state so it tracks the frame
        // exactly: high after the start edge, low after the stop edge.
        busy_nxt   = (state_nxt == DATA) || (state_nxt == PARITY) ||
                     (state_nxt == STOP);
    end

    // Datapath and registered outputs
    always_ff @(posedge tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg         <= '0;
            bit_cnt           <= '0;
            parity_bit        <= 1'b0;
            bus.rx_data_out   <= '0;
            bus.rx_valid      <= 1'b0;
            bus.parity_error  <= 1'b0;
            bus.framing_error <= 1'b0;
            bus.busy          <= 1'b0;
        end else begin
            bus.rx_valid <= frame_done;
            bus.busy     <= busy_nxt;

            if (start_det) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                // Right shift: the first bit received ends up in bit 0.
                shift_reg <= {bus.rx_data_in, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end

            if (parity_cap) begin
                parity_bit <= bus.rx_data_in;
            end

            // Errored frames still overwrite the data byte and both flags.
            if (frame_done) begin
                bus.rx_data_out   <= shift_reg;
                bus.parity_error  <= (^shift_reg) ^ parity_bit;
                bus.framing_error <= ~bus.rx_data_in;
            end
        end
    end

endmodule

// File: tb/tb_receiver.sv
// ---------------------------------------------------------------------------
// tb_receiver
// Drives serial frames into the receiver and checks every completion against
// expectations queued by the stimulus side; a separate monitor pops and
// compares whenever rx_valid is seen, and checks held outputs otherwise.
// ---------------------------------------------------------------------------
module tb_receiver;

    typedef struct {
        logic [7:0] data;
        bit         perr;
        bit         ferr;
        int         cyc;
    } exp_t;

    logic tx_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   cyc    = 0;

    receiver_if #(.DATA_WIDTH(8)) bus ();

    receiver #(.DATA_WIDTH(8)) dut (
        .tx_clk (tx_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 tx_clk = ~tx_clk;

    always @(posedge tx_clk) cyc <= cyc + 1;

    exp_t       q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] last_data = 8'h00;
    bit         last_perr = 1'b0;
    bit         last_ferr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: outputs are stable at the falling edge.
    always @(negedge tx_clk) begin
        if (!rst_n) begin
            last_data = 8'h00;
            last_perr = 1'b0;
            last_ferr = 1'b0;
        end else if (bus.rx_valid) begin
            if (q.size() == 0) begin
                check("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("valid_cycle", cyc, mon_e.cyc);
                check("rx_data_out", {24'd0, bus.rx_data_out}, {24'd0, mon_e.data});
                check("parity_error", {31'd0, bus.parity_error}, {31'd0, mon_e.perr});
                check("framing_error", {31'd0, bus.framing_error}, {31'd0, mon_e.ferr});
                check("busy_at_valid", {31'd0, bus.busy}, 32'd0);
                last_data = mon_e.data;
                last_perr = mon_e.perr;
                last_ferr = mon_e.ferr;
            end
        end else begin
            check("hold_data", {24'd0, bus.rx_data_out}, {24'd0, last_data});
            check("hold_perr", {31'd0, bus.parity_error}, {31'd0, last_perr});
            check("hold_ferr", {31'd0, bus.framing_error}, {31'd0, last_ferr});
        end
    end

    // One frame: start, 8 data LSB first, parity (optionally corrupted), stop.
    task automatic send_frame(input logic [7:0] d, input bit flip_par,
                              input bit stop_bit, input bit wobble_en);
        logic [10:0] bits;
        logic        par;
        exp_t        e;
        par  = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
        par  = par ^ flip_par;
        bits = {stop_bit, par, d, 1'b0};
        for (int k = 0; k < 11; k++) begin
            @(negedge tx_clk);
            if (k == 1) check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
            #1;
            if (k == 0) begin
                e.data = d;
                e.perr = (($countones(d) % 2) == 1) != (par == 1'b1);
                e.ferr = !stop_bit;
                e.cyc  = cyc + 11;
                q.push_back(e);
                bus.rx_enable = 1'b1;
            end else if (wobble_en) begin
                bus.rx_enable = 1'($urandom_range(0, 1));
            end
            bus.rx_data_in = bits[k];
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge tx_clk);
            #1;
            bus.rx_data_in = 1'b1;
        end
    endtask

    // Line held low with rx_enable=1: must not start a frame after a bad stop.
    task automatic low_cycles(input int n);
        repeat (n) begin
            @(negedge tx_clk);
            check("busy_wait_idle", {31'd0, bus.busy}, 32'd0);
            #1;
            bus.rx_enable  = 1'b1;
            bus.rx_data_in = 1'b0;
        end
        @(negedge tx_clk);
        check("busy_wait_idle", {31'd0, bus.busy}, 32'd0);
        #1;
        bus.rx_data_in = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_valid"}, {31'd0, bus.rx_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_rx_data_out"}, {24'd0, bus.rx_data_out}, 32'd0);
        check({tag, "_parity_error"}, {31'd0, bus.parity_error}, 32'd0);
        check({tag, "_framing_error"}, {31'd0, bus.framing_error}, 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        bit         flip;
        bit         stop;
        bus.rx_enable  = 1'b0;
        bus.rx_data_in = 1'b1;
        rst_n          = 1'b0;
        repeat (3) @(negedge tx_clk);
        check_reset_outputs("por");
        #1;
        rst_n         = 1'b1;
        bus.rx_enable = 1'b1;
        idle_cycles(3);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);

        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        send_frame(8'h03, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);

        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        low_cycles(3);
        send_frame(8'h7E, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);

        send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);

        // Start bit on the line with rx_enable low: nothing may happen.
        @(negedge tx_clk);
        #1;
        bus.rx_enable  = 1'b0;
        bus.rx_data_in = 1'b0;
        repeat (4) begin
            @(negedge tx_clk);
            check("busy_enable_low", {31'd0, bus.busy}, 32'd0);
        end
        #1;
        bus.rx_data_in = 1'b1;
        bus.rx_enable  = 1'b1;
        idle_cycles(2);

        // Reset after 4 data bits of 0xFF: frame aborted, no completion.
        for (int k = 0; k < 5; k++) begin
            @(negedge tx_clk);
            #1;
            bus.rx_data_in = (k == 0) ? 1'b0 : 1'b1;
        end
        @(negedge tx_clk);
        #1;
        rst_n = 1'b0;
        repeat (2) begin
            @(negedge tx_clk);
            check_reset_outputs("mid_reset");
        end
        #1;
        rst_n          = 1'b1;
        bus.rx_data_in = 1'b1;
        idle_cycles(2);
        send_frame(8'h81, 1'b0, 1'b1, 1'b0);
        idle_cycles(2);

        // Loopback sweep, back to back.
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b0, 1'b1, 1'b0);
        end
        idle_cycles(2);

        // Randomised frames with occasional parity/stop errors and enable wobble.
        for (int i = 0; i < 300; i++) begin
            d    = 8'($urandom);
            flip = ($urandom_range(0, 7) == 0);
            stop = ($urandom_range(0, 7) != 0);
            send_frame(d, flip, stop, 1'b1);
            if (!stop) low_cycles($urandom_range(0, 3));
            else idle_cycles($urandom_range(0, 2));
        end
        idle_cycles(3);

        for (int t = 0; t < 40 && q.size() != 0; t++) @(negedge tx_clk);
        check("queue_drained", q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
